zero_cross_meter: RTL and testbench

- Measurement stage directly downstream of the PDM decoder. Consumes the recovered 16-bit signed left/right audio words and reports the averaged waveform period in clk cycles, plus the peak amplitude.
- Used by equalizer band-verification benches and the on-board self-test path to confirm that the audio in each filter band sits in the expected frequency range.
- Rising zero crossings are detected with hysteresis, so noise around zero is rejected.

---
 rtl/zero_cross_meter.sv | 172 +++++++++++++++++
 tb/tb_zero_cross_meter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/zero_cross_meter.sv
// Averaged waveform period and peak amplitude meter for the decoded stereo stream.
// Rising zero crossings are detected with +/-HYST hysteresis on the mono mix.
module zero_cross_meter #(
  parameter logic [15:0] HYST     = 16'd256,
  parameter int          LOG2_PER = 2,
  parameter int          SETTLE   = 2,
  parameter logic [21:0] CYC_MAX  = 22'h3FFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        smpl_vld,
  input  logic [15:0] lft_in,
  input  logic [15:0] rght_in,
  output logic [21:0] period,
  output logic [11:0] amp,
  output logic        meas_vld,
  output logic        timeout
);

  localparam int ACC_W = 22 + LOG2_PER;
  localparam int PER_W = LOG2_PER + 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'((1 << LOG2_PER) - 1);
  localparam logic signed [16:0] HYST_P = {1'b0, HYST};
  localparam logic signed [16:0] HYST_N = -HYST_P;

  typedef enum logic [1:0] {SGN_UNK, SGN_POS, SGN_NEG} sgn_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_MEAS, ST_REPORT} state_t;

  logic [15:0]      mono_q, mono_d, abs_q, abs_d;
  logic             vld1_q;
  sgn_t             sgn_q, sgn_d, sgn_last_q;
  logic             rise_q, rise_d;
  state_t           state_q, state_d;
  logic [21:0]      cyc_q, cyc_d;
  logic [7:0]       disc_q, disc_d;
  logic [PER_W-1:0] per_q, per_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [15:0]      peak_q, peak_d;
  logic [21:0]      period_q, period_d;
  logic [11:0]      amp_q, amp_d;
  logic             meas_vld_q, meas_vld_d;
  logic             timeout_q, timeout_d;
  logic signed [16:0] mono_ext;

  always_comb begin
    mono_d = mono_q;
    abs_d  = abs_q;
    if (smpl_vld) begin
      mono_d = 16'(($signed({lft_in[15], lft_in}) + $signed({rght_in[15], rght_in})) >>> 1);
      abs_d  = mono_d[15] ? (~mono_d + 16'd1) : mono_d;
    end
  end

  assign mono_ext = {mono_q[15], mono_q};

  always_comb begin
    sgn_d = sgn_q;
    if (vld1_q) begin
      if (mono_ext >= HYST_P)      sgn_d = SGN_POS;
      else if (mono_ext <= HYST_N) sgn_d = SGN_NEG;
    end
    // sgn_last_q lags sgn_q by one clk, so a NEG->POS step yields a single pulse
    rise_d = (sgn_last_q == SGN_NEG) && (sgn_q == SGN_POS);
  end

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    disc_d     = disc_q;
    per_d      = per_q;
    acc_d      = acc_q;
    peak_d     = peak_q;
    period_d   = period_q;
    amp_d      = amp_q;
    meas_vld_d = 1'b0;
    timeout_d  = timeout_q;
    if (state_q == ST_IDLE) begin
      cyc_d = '0;
      if (sgn_q != SGN_UNK) begin
        state_d = ST_ARM;
        disc_d  = 8'(SETTLE);
      end
    end else if (cyc_q == CYC_MAX) begin
      timeout_d = 1'b1;
      period_d  = 22'h3FFFFF;
      cyc_d     = '0;
      state_d   = ST_IDLE;
    end else begin
      cyc_d = cyc_q + 22'd1;
      case (state_q)
        ST_ARM: begin
          if (rise_q) begin
            cyc_d = '0;
            if (disc_q == 8'd0) begin
              state_d = ST_MEAS;
              per_d   = '0;
              acc_d   = '0;
              peak_d  = '0;
            end else begin
              disc_d = disc_q - 8'd1;
            end
          end
        end
        ST_MEAS: begin
          peak_d = (abs_q > peak_q) ? abs_q : peak_q;
          if (rise_q) begin
            // the crossing cycle itself belongs to the period just closed
            acc_d = acc_q + ACC_W'(cyc_q) + ACC_W'(1);
            cyc_d = '0;
            per_d = per_q + PER_W'(1);
            if (per_q == PER_LAST) state_d = ST_REPORT;
          end
        end
        ST_REPORT: begin
          period_d   = 22'(acc_q >> LOG2_PER);
          amp_d      = peak_q[15:4];
          meas_vld_d = 1'b1;
          acc_d      = '0;
          per_d      = '0;
          peak_d     = '0;
          state_d    = ST_MEAS;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      mono_q     <= '0;
      abs_q      <= '0;
      vld1_q     <= 1'b0;
      sgn_q      <= SGN_UNK;
      sgn_last_q <= SGN_UNK;
      rise_q     <= 1'b0;
      state_q    <= ST_IDLE;
      cyc_q      <= '0;
      disc_q     <= '0;
      per_q      <= '0;
      acc_q      <= '0;
      peak_q     <= '0;
      period_q   <= '0;
      amp_q      <= '0;
      meas_vld_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      mono_q     <= mono_d;
      abs_q      <= abs_d;
      vld1_q     <= smpl_vld;
      sgn_q      <= sgn_d;
      sgn_last_q <= sgn_q;
      rise_q     <= rise_d;
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      disc_q     <= disc_d;
      per_q      <= per_d;
      acc_q      <= acc_d;
      peak_q     <= peak_d;
      period_q   <= period_d;
      amp_q      <= amp_d;
      meas_vld_q <= meas_vld_d;
      timeout_q  <= timeout_d;
    end
  end

  assign period   = period_q;
  assign amp      = amp_q;
  assign meas_vld = meas_vld_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_zero_cross_meter.sv
// Directed bench for zero_cross_meter using square-wave stimulus of known period.
// The saturation limit is shortened so the timeout path fits in a short run.
module tb_zero_cross_meter;

  localparam logic [21:0] CYC_MAX = 22'd4095;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        smpl_vld;
  logic [15:0] lft_in, rght_in;
  logic [21:0] period;
  logic [11:0] amp;
  logic        meas_vld;
  logic        timeout;

  int vectors = 0;
  int miscompares = 0;

  int          gen_mode = 0;
  int          gen_half = 50;
  logic [15:0] gen_pl = 16'd0, gen_nl = 16'd0, gen_pr = 16'd0, gen_nr = 16'd0;
  int          ph = 0;

  zero_cross_meter #(.CYC_MAX(CYC_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .smpl_vld(smpl_vld),
    .lft_in(lft_in), .rght_in(rght_in), .period(period), .amp(amp),
    .meas_vld(meas_vld), .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    smpl_vld = 1'b0;
    lft_in   = 16'd0;
    rght_in  = 16'd0;
    forever begin
      @(negedge clk);
      if (gen_mode == 0) begin
        smpl_vld = 1'b0;
        lft_in   = 16'd0;
        rght_in  = 16'd0;
      end else if (gen_mode == 1) begin
        smpl_vld = 1'b1;
        lft_in   = (ph < gen_half) ? gen_pl : gen_nl;
        rght_in  = (ph < gen_half) ? gen_pr : gen_nr;
        ph = (ph + 1 >= 2 * gen_half) ? 0 : ph + 1;
      end else begin
        smpl_vld = 1'b1;
        lft_in   = gen_pl;
        rght_in  = gen_pr;
      end
    end
  end

  task automatic wait_vld(input int limit, output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    while (n < limit && !seen) begin
      @(negedge clk);
      n++;
      if (meas_vld) seen = 1'b1;
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic set_square(input int half, input logic [15:0] pl, input logic [15:0] nl,
                            input logic [15:0] pr, input logic [15:0] nr);
    gen_half = half;
    gen_pl = pl; gen_nl = nl; gen_pr = pr; gen_nr = nr;
    gen_mode = 1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({period, amp, meas_vld, timeout} !== 36'd0) begin
      miscompares++;
      $display("FAIL reset_in: period=%0d amp=%0d vld=%0b to=%0b, required all 0", period, amp, meas_vld, timeout);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (period !== 22'd0 || amp !== 12'd0) begin
      miscompares++;
      $display("FAIL reset_out: period=%0d amp=%0d, required 0 0", period, amp);
    end
    vectors++;
    if (meas_vld !== 1'b0 || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_flags: vld=%0b to=%0b, required 0 0", meas_vld, timeout);
    end
    $display("reset: period=%0d amp=%0d vld=%0b timeout=%0b", period, amp, meas_vld, timeout);
  endtask

  task automatic test_square(input string name, input int half, input logic [15:0] pos,
                             input logic [15:0] neg, input logic [11:0] exp_amp);
    int n;
    bit seen;
    gen_mode = 0;
    pulse_clr();
    set_square(half, pos, neg, pos, neg);
    wait_vld(20 * half + 400, n, seen);
    vectors++;
    if (!seen || period !== 22'(2 * half) || amp !== exp_amp || timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_first: seen=%0b period=%0d amp=%0d to=%0b, required period=%0d amp=%0d to=0",
               name, seen, period, amp, timeout, 2 * half, exp_amp);
    end
    $display("%s first: cycles=%0d period=%0d amp=%0d", name, n, period, amp);
    @(negedge clk);
    vectors++;
    if (meas_vld !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_pulse: meas_vld=%0b one cycle later, required 0", name, meas_vld);
    end
    wait_vld(20 * half, n, seen);
    vectors++;
    if (!seen || n + 1 != 8 * half || period !== 22'(2 * half) || amp !== exp_amp) begin
      miscompares++;
      $display("FAIL %s_back_to_back: seen=%0b gap=%0d period=%0d amp=%0d, required gap=%0d period=%0d amp=%0d",
               name, seen, n + 1, period, amp, 8 * half, 2 * half, exp_amp);
    end
    $display("%s next: gap=%0d period=%0d amp=%0d", name, n + 1, period, amp);
  endtask

  task automatic test_cancel();
    int n;
    bit seen;
    gen_mode = 0;
    pulse_clr();
    set_square(50, 16'd8000, 16'hE0C0, 16'hE0C0, 16'd8000);
    wait_vld(int'(CYC_MAX) + 500, n, seen);
    vectors++;
    if (seen || timeout !== 1'b0 || period !== 22'd0 || amp !== 12'd0) begin
      miscompares++;
      $display("FAIL cancel: seen=%0b to=%0b period=%0d amp=%0d, required no vld, to=0, 0, 0",
               seen, timeout, period, amp);
    end
    $display("cancel: cycles=%0d vld_seen=%0b timeout=%0b", n, seen, timeout);
  endtask

  task automatic test_timeout();
    int  n;
    bit  hit;
    bit  vld_seen;
    gen_mode = 0;
    pulse_clr();
    gen_pl = 16'd8000;
    gen_pr = 16'd8000;
    gen_mode = 2;
    n = 0;
    while (!(smpl_vld && lft_in == 16'd8000) && n < 10) begin
      @(posedge clk);
      n++;
    end
    n = 0;
    hit = 1'b0;
    vld_seen = 1'b0;
    while (!hit && n < int'(CYC_MAX) + 200) begin
      @(negedge clk);
      n++;
      if (meas_vld) vld_seen = 1'b1;
      if (timeout) hit = 1'b1;
    end
    vectors++;
    if (!hit || n != int'(CYC_MAX) + 4) begin
      miscompares++;
      $display("FAIL timeout_latency: hit=%0b cycles=%0d, required hit=1 cycles=%0d", hit, n, int'(CYC_MAX) + 4);
    end
    vectors++;
    if (period !== 22'h3FFFFF || vld_seen) begin
      miscompares++;
      $display("FAIL timeout_period: period=%h vld_seen=%0b, required 3fffff and no vld", period, vld_seen);
    end
    repeat (50) @(negedge clk);
    vectors++;
    if (timeout !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_sticky: timeout=%0b, required 1", timeout);
    end
    $display("timeout: cycles=%0d period=%h timeout=%0b", n, period, timeout);
    gen_mode = 0;
    pulse_clr();
    vectors++;
    if (timeout !== 1'b0 || period !== 22'd0) begin
      miscompares++;
      $display("FAIL timeout_clr: timeout=%0b period=%h, required 0 0", timeout, period);
    end
  endtask

  task automatic test_restart(input bit use_rst);
    int n;
    bit seen;
    string name;
    name = use_rst ? "rst_mid" : "clr_mid";
    gen_mode = 0;
    pulse_clr();
    set_square(50, 16'd8000, 16'hE0C0, 16'd8000, 16'hE0C0);
    wait_vld(1500, n, seen);
    repeat (150) @(negedge clk);
    vectors++;
    if (!seen || period !== 22'd100) begin
      miscompares++;
      $display("FAIL %s_pre: seen=%0b period=%0d, required 1 100", name, seen, period);
    end
    if (use_rst) begin
      #2 rst_n = 1'b0;
      #1;
    end else begin
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
    end
    vectors++;
    if ({period, amp, meas_vld, timeout} !== 36'd0) begin
      miscompares++;
      $display("FAIL %s_clear: period=%0d amp=%0d vld=%0b to=%0b, required all 0",
               name, period, amp, meas_vld, timeout);
    end
    if (use_rst) begin
      @(negedge clk);
      rst_n = 1'b1;
    end
    wait_vld(1500, n, seen);
    vectors++;
    if (!seen || n < 600 || n > 720 || period !== 22'd100 || amp !== 12'd500) begin
      miscompares++;
      $display("FAIL %s_resume: seen=%0b cycles=%0d period=%0d amp=%0d, required cycles 600..720 period=100 amp=500",
               name, seen, n, period, amp);
    end
    $display("%s: resume cycles=%0d period=%0d amp=%0d", name, n, period, amp);
  endtask

  initial begin
    test_reset();
    test_square("sq100", 50, 16'd8000, 16'hE0C0, 12'd500);
    test_square("fullscale", 20, 16'h7FFF, 16'h8000, 12'h800);
    test_square("sq60_low", 30, 16'd4000, 16'hF060, 12'd250);
    test_cancel();
    test_timeout();
    test_restart(1'b0);
    test_restart(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
